unary2binary: RTL and testbench
===============================

Name: unary2binary

Overview:
Temporal-code decoder, the receive-side counterpart of binary2unary. Samples a single-bit unary (spike) line once per aclk across a gamma cycle of GAMMA_CYCLE_WIDTH slots. At the end of each gamma cycle it emits the recovered binary value with a one-cycle valid strobe. Encoding is selected at elaboration time: rising-edge time, falling-edge time, or pulse width.

Parameters:
GAMMA_CYCLE_WIDTH, 16, slots per gamma cycle; must be a power of two and at least 2.
PULSE_WIDTH, 8, nominal encoder pulse width; used only by the pulse-width saturation rule.
OUTPUT_WIDTH, $clog2(GAMMA_CYCLE_WIDTH), width of the decoded value (derived; do not override).
MODE, 0, decode scheme: 0 = rising-edge time, 1 = falling-edge time, 2 = pulse width.

Ports:
aclk  input  1  clock; all state updates on posedge.
grst  input  1  reset; synchronous, active-high.
unary_input  input  1  unary/spike line from the encoder or network.
binary_output  output  OUTPUT_WIDTH  decoded value; registered; holds until the next valid.
no_edge  output  1  no qualifying event in the last gamma cycle (MODE 0/1); always 0 in MODE 2.
valid  output  1  one-cycle strobe; binary_output and no_edge are valid in this cycle.

Behaviour:
- Reset (grst=1 at posedge):
  - slot counter = 0; binary_output = 0; no_edge = 0; valid = 0.
  - prev_sample = 0; edge_seen = 0; accumulator = 0.
- Slot counter:
  - The first posedge with grst=0 samples slot 0.
  - Increments by 1 per cycle and wraps from G-1 to 0 (G = GAMMA_CYCLE_WIDTH).
  - Gamma cycles run back-to-back; there are no idle cycles.
- Sampling: on each non-reset posedge, unary_input is sampled as slot s = current counter value.
- prev_sample is treated as 0 at slot 0 of every gamma cycle; no history carries across the gamma boundary.
- MODE 0 (rising):
  - Event = first slot with sample 1 and prev_sample 0.
  - Input already high at slot 0 counts as an event at slot 0.
  - The event's slot index is latched; later edges in the same gamma cycle are ignored.
- MODE 1 (falling):
  - Event = first slot with sample 0 and prev_sample 1, within the same gamma cycle.
  - The event's slot index is latched; later edges are ignored.
  - A pulse still high at slot G-1 produces no event.
- MODE 2 (pulse width):
  - Accumulator counts slots sampled 1 across the whole gamma cycle.
  - Counts need not be contiguous.
  - The result saturates at G-1 (all-ones), since a count of G is unrepresentable.
- End of gamma cycle: on the posedge that samples slot G-1, the following are registered from the final result, including the slot G-1 sample:
  - binary_output = latched slot (MODE 0/1) or accumulator (MODE 2).
  - no_edge = !edge_seen (MODE 0/1).
  - valid = 1.
  - If there is no event, binary_output = 0 and no_edge = 1.
  - Per-gamma state is cleared in the same cycle.
- Latency and valid timing:
  - valid is high in the cycle after slot G-1 was sampled, which is the same cycle slot 0 of the next gamma is sampled.
  - valid is exactly one cycle wide, once per G cycles.
- Reset mid-gamma: the partial gamma is discarded and no valid is issued for it. Outputs return to reset values; the counter restarts at slot 0 after deassertion.
- Reset asserted in the same cycle the valid would be produced: reset wins, and valid stays 0.
- No combinational path from unary_input to any output.

Test Plan:
- MODE 0, G=16: reset 2 cycles, then the encoder drives value 1 (rise at slot 1, high 8 slots) -> valid 16 cycles after reset release; binary_output=1, no_edge=0.
- MODE 0: rise at slot 8 plus a second rise at slot 12 -> binary_output=8 (first edge only); input high at slot 0 -> binary_output=0, no_edge=0; input low for the whole gamma -> binary_output=0, no_edge=1.
- MODE 1: high slots 3..10, low at slot 11 -> binary_output=11. High slots 9..15 (no fall) -> no_edge=1.
- MODE 2: high slots 2..9 -> binary_output=8. High for all 16 slots -> binary_output=15 (saturated). Split pulses of 3+2 -> 5.
- Back-to-back gammas in MODE 0 with values 1, 8, 15 -> three valid pulses spaced exactly 16 cycles apart; binary_output holds each value between strobes.
- grst asserted at slot 7 of a gamma with an edge already seen -> no valid for that gamma; outputs 0; the next full gamma decodes correctly.

Source files
------------

// File: rtl/unary2binary.sv
// Temporal-code decoder: samples a unary spike line once per slot over a gamma
// cycle and emits the recovered binary value with a one-cycle valid strobe.
module unary2binary #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int OUTPUT_WIDTH      = $clog2(GAMMA_CYCLE_WIDTH),
  parameter int MODE              = 0
) (
  input  logic                    aclk,
  input  logic                    grst,
  input  logic                    unary_input,
  output logic [OUTPUT_WIDTH-1:0] binary_output,
  output logic                    no_edge,
  output logic                    valid
);

  // The pulse-width accumulator must hold a full gamma of ones before saturation.
  localparam int ACC_MAX = (PULSE_WIDTH > GAMMA_CYCLE_WIDTH) ? PULSE_WIDTH : GAMMA_CYCLE_WIDTH;
  localparam int ACC_W   = $clog2(ACC_MAX + 1);
  localparam logic [OUTPUT_WIDTH-1:0] LAST_SLOT = OUTPUT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [ACC_W-1:0]        ACC_SAT   = ACC_W'(GAMMA_CYCLE_WIDTH - 1);

  logic [OUTPUT_WIDTH-1:0] slot;
  logic                    prev_sample;
  logic                    edge_seen;
  logic [OUTPUT_WIDTH-1:0] event_slot;
  logic [ACC_W-1:0]        acc;

  logic                    prev_eff;
  logic                    hit;
  logic                    edge_next;
  logic [OUTPUT_WIDTH-1:0] event_next;
  logic [ACC_W-1:0]        acc_next;
  logic [OUTPUT_WIDTH-1:0] result;
  logic                    result_no_edge;
  logic                    last;

  always_comb begin
    prev_eff       = 1'b0;
    hit            = 1'b0;
    edge_next      = edge_seen;
    event_next     = event_slot;
    acc_next       = acc;
    result         = '0;
    result_no_edge = 1'b0;
    last           = (slot == LAST_SLOT);

    // History never crosses the gamma boundary, so slot 0 sees a low predecessor.
    prev_eff = (slot == '0) ? 1'b0 : prev_sample;
    if (MODE == 0) begin
      hit = unary_input & ~prev_eff;
    end else if (MODE == 1) begin
      hit = ~unary_input & prev_eff;
    end
    edge_next  = edge_seen | hit;
    event_next = (hit && !edge_seen) ? slot : event_slot;
    acc_next   = acc + ACC_W'(unary_input);

    if (MODE == 2) begin
      result = (acc_next > ACC_SAT) ? LAST_SLOT : acc_next[OUTPUT_WIDTH-1:0];
    end else begin
      result         = edge_next ? event_next : '0;
      result_no_edge = ~edge_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      slot          <= '0;
      prev_sample   <= 1'b0;
      edge_seen     <= 1'b0;
      event_slot    <= '0;
      acc           <= '0;
      binary_output <= '0;
      no_edge       <= 1'b0;
      valid         <= 1'b0;
    end else begin
      slot  <= slot + 1'b1;
      valid <= last;
      if (last) begin
        binary_output <= result;
        no_edge       <= result_no_edge;
        prev_sample   <= 1'b0;
        edge_seen     <= 1'b0;
        event_slot    <= '0;
        acc           <= '0;
      end else begin
        prev_sample <= unary_input;
        edge_seen   <= edge_next;
        event_slot  <= event_next;
        acc         <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_unary2binary.sv
// Directed bench: drives one gamma pattern into rising, falling and pulse-width
// decoders in parallel and compares each against hand-computed results.
module tb_unary2binary;

  logic       aclk;
  logic       grst;
  logic       unary_input;
  logic [3:0] bo0, bo1, bo2;
  logic       ne0, ne1, ne2;
  logic       v0, v1, v2;

  int checks = 0;
  int errors = 0;
  int prev_bo[3];
  int prev_ne[3];

  typedef struct {
    logic [15:0] pattern;
    int          exp0;
    int          ne0;
    int          exp1;
    int          ne1;
    int          exp2;
  } vec_t;

  vec_t vectors[13];

  unary2binary #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(0)) dut0 (
    .aclk(aclk), .grst(grst), .unary_input(unary_input),
    .binary_output(bo0), .no_edge(ne0), .valid(v0));
  unary2binary #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(1)) dut1 (
    .aclk(aclk), .grst(grst), .unary_input(unary_input),
    .binary_output(bo1), .no_edge(ne1), .valid(v1));
  unary2binary #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(2)) dut2 (
    .aclk(aclk), .grst(grst), .unary_input(unary_input),
    .binary_output(bo2), .no_edge(ne2), .valid(v2));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_valid"}, int'({v2, v1, v0}), 0);
    check_output({tag, "_bo0"}, int'(bo0), 0);
    check_output({tag, "_bo1"}, int'(bo1), 0);
    check_output({tag, "_bo2"}, int'(bo2), 0);
    check_output({tag, "_ne"}, int'({ne2, ne1, ne0}), 0);
    for (int k = 0; k < 3; k++) begin
      prev_bo[k] = 0;
      prev_ne[k] = 0;
    end
  endtask

  // Drives slots 0..n-1; between strobes valid must stay low and outputs must hold.
  task automatic apply_stimulus(input logic [15:0] pattern, input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      unary_input = pattern[i];
      @(negedge aclk);
      if (i < 15) begin
        if ({v2, v1, v0} != 3'b000) bad++;
        if (int'(bo0) != prev_bo[0] || int'(bo1) != prev_bo[1] || int'(bo2) != prev_bo[2]) bad++;
        if (int'(ne0) != prev_ne[0] || int'(ne1) != prev_ne[1] || int'(ne2) != prev_ne[2]) bad++;
      end
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int    bad;
    string tag;
    tag = $sformatf("vec%0d", idx);
    apply_stimulus(v.pattern, 16, bad);
    check_output({tag, "_hold"}, bad, 0);
    check_output({tag, "_valid"}, int'({v2, v1, v0}), 7);
    check_output({tag, "_rise_value"}, int'(bo0), v.exp0);
    check_output({tag, "_rise_no_edge"}, int'(ne0), v.ne0);
    check_output({tag, "_fall_value"}, int'(bo1), v.exp1);
    check_output({tag, "_fall_no_edge"}, int'(ne1), v.ne1);
    check_output({tag, "_width_value"}, int'(bo2), v.exp2);
    check_output({tag, "_width_no_edge"}, int'(ne2), 0);
    prev_bo[0] = v.exp0; prev_ne[0] = v.ne0;
    prev_bo[1] = v.exp1; prev_ne[1] = v.ne1;
    prev_bo[2] = v.exp2; prev_ne[2] = 0;
  endtask

  initial begin
    int bad;
    // pattern bit i is the sample for slot i
    vectors[0]  = '{16'h01FE,  1, 0,  9, 0,  8};
    vectors[1]  = '{16'hFF00,  8, 0,  0, 1,  8};
    vectors[2]  = '{16'h8000, 15, 0,  0, 1,  1};
    vectors[3]  = '{16'h3300,  8, 0, 10, 0,  4};
    vectors[4]  = '{16'h000F,  0, 0,  4, 0,  4};
    vectors[5]  = '{16'h0000,  0, 1,  0, 1,  0};
    vectors[6]  = '{16'h07F8,  3, 0, 11, 0,  8};
    vectors[7]  = '{16'hFE00,  9, 0,  0, 1,  7};
    vectors[8]  = '{16'h03FC,  2, 0, 10, 0,  8};
    vectors[9]  = '{16'hFFFF,  0, 0,  0, 1, 15};
    vectors[10] = '{16'h0C70,  4, 0,  7, 0,  5};
    vectors[11] = '{16'h4000, 14, 0, 15, 0,  1};
    vectors[12] = '{16'h01FE,  1, 0,  9, 0,  8};

    grst        = 1'b1;
    unary_input = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_state("reset");

    grst = 1'b0;
    for (int i = 0; i < 12; i++) run_vector(vectors[i], i);

    // Reset at slot 7 after a rising edge at slot 1: partial gamma is dropped.
    apply_stimulus(16'h01FE, 7, bad);
    check_output("midreset_pre_hold", bad, 0);
    grst        = 1'b1;
    unary_input = 1'b1;
    @(negedge aclk);
    check_reset_state("midreset");
    grst = 1'b0;
    run_vector(vectors[3], 100);

    // Reset on the posedge that samples slot 15: reset wins over valid.
    apply_stimulus(16'h01FE, 15, bad);
    check_output("lastreset_pre_hold", bad, 0);
    grst        = 1'b1;
    unary_input = 1'b1;
    @(negedge aclk);
    check_reset_state("lastreset");
    grst = 1'b0;
    run_vector(vectors[12], 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
